// File: rtl/heater_pkg.sv
// heater_pkg: shared channel state type and counter width helpers for the heater scheduler.
package heater_pkg;
  typedef enum logic [2:0] {IDLE, WAIT, ON, CLEAR, LOCKED} chan_state_e;
  localparam int RETRY_W = 8;
  function automatic int slot_w(input int slot_cycles);
    return (slot_cycles > 2) ? $clog2(slot_cycles) : 1;
  endfunction
  function automatic int clr_w(input int clr_cycles);
    return (clr_cycles > 2) ? $clog2(clr_cycles) : 1;
  endfunction
endpackage

// File: rtl/heater_chan_fsm.sv
// heater_chan_fsm: per-channel IDLE/WAIT/ON/CLEAR/LOCKED sequencer with slot, clear and retry tracking.
module heater_chan_fsm
  import heater_pkg::*;
#(
  parameter int SLOT_CYCLES = 256,
  parameter int CLR_CYCLES  = 8,
  parameter int MAX_RETRY   = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  input  logic grant_i,
  input  logic err_i,
  input  logic ack_i,
  output logic wait_o,
  output logic on_o,
  output logic leave_o,
  output logic en_o,
  output logic clr_o,
  output logic lock_o
);
  localparam int SLOT_W = slot_w(SLOT_CYCLES);
  localparam int CLR_W  = clr_w(CLR_CYCLES);
  chan_state_e        state_q, state_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic [CLR_W-1:0]   clr_q, clr_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               slot_end, clr_end;
  assign slot_end = slot_q == SLOT_W'(SLOT_CYCLES - 1);
  assign clr_end  = clr_q == CLR_W'(CLR_CYCLES - 1);
  assign wait_o   = (state_q == WAIT) && req_i;
  assign on_o     = state_q == ON;
  // Departures from ON are visible to the arbiter so their budget can be reused this cycle
  assign leave_o  = on_o && (err_i || !req_i || slot_end);
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    clr_d   = clr_q;
    retry_d = retry_q;
    case (state_q)
      IDLE: state_d = req_i ? WAIT : IDLE;
      WAIT: begin
        if (!req_i) state_d = IDLE;
        else if (grant_i) begin
          state_d = ON;
          slot_d  = '0;
        end
      end
      ON: begin
        if (err_i) begin
          state_d = CLEAR;
          clr_d   = '0;
          retry_d = retry_q + RETRY_W'(1);
        end else if (!req_i || slot_end) begin
          state_d = req_i ? WAIT : IDLE;
          retry_d = slot_end ? '0 : retry_q;
        end else slot_d = slot_q + SLOT_W'(1);
      end
      CLEAR: begin
        if (clr_end) state_d = (err_i || retry_q == RETRY_W'(MAX_RETRY)) ? LOCKED : req_i ? WAIT : IDLE;
        else clr_d = clr_q + CLR_W'(1);
      end
      LOCKED: begin
        if (ack_i) begin
          state_d = IDLE;
          retry_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      slot_q  <= '0;
      clr_q   <= '0;
      retry_q <= '0;
      en_o    <= 1'b0;
      clr_o   <= 1'b0;
      lock_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      clr_q   <= clr_d;
      retry_q <= retry_d;
      en_o    <= state_d == ON;
      clr_o   <= state_d == CLEAR;
      lock_o  <= state_d == LOCKED;
    end
  end
endmodule

// File: rtl/heater_sched.sv
// heater_sched: round-robin heater slot arbiter under a concurrent-power budget.
// Define HEATER_SCHED_ERR_CNT_EN to add the saturating err_total error counter output.
module heater_sched
  import heater_pkg::*;
#(
  parameter int N           = 18,
  parameter int MAX_ACTIVE  = 4,
  parameter int SLOT_CYCLES = 256,
  parameter int CLR_CYCLES  = 8,
  parameter int MAX_RETRY   = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0]           req,
  input  logic [N-1:0]           fault_ack,
  input  logic [N-1:0]           heater_error,
  output logic [N-1:0]           heater_enable,
  output logic [N-1:0]           heater_err_clear,
  output logic [N-1:0]           fault,
  output logic [$clog2(N+1)-1:0] active_cnt
`ifdef HEATER_SCHED_ERR_CNT_EN
  ,
  output logic [7:0]             err_total
`endif
);
  localparam int CNT_W = $clog2(N + 1);
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
  logic [N-1:0]     wait_v, on_v, leave_v, grant_v;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d, gnt_idx, idx;
  logic [CNT_W-1:0] stay_cnt, act_d;
  logic             found, grant_en;
  for (genvar i = 0; i < N; i++) begin : g_chan
    heater_chan_fsm #(
      .SLOT_CYCLES(SLOT_CYCLES),
      .CLR_CYCLES (CLR_CYCLES),
      .MAX_RETRY  (MAX_RETRY)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .req_i  (req[i]),
      .grant_i(grant_v[i]),
      .err_i  (heater_error[i]),
      .ack_i  (fault_ack[i]),
      .wait_o (wait_v[i]),
      .on_o   (on_v[i]),
      .leave_o(leave_v[i]),
      .en_o   (heater_enable[i]),
      .clr_o  (heater_err_clear[i]),
      .lock_o (fault[i])
    );
  end
  // Budget counts only channels that remain ON past this edge
  always_comb begin
    stay_cnt = '0;
    found    = 1'b0;
    gnt_idx  = '0;
    idx      = '0;
    for (int k = 0; k < N; k++) stay_cnt = stay_cnt + CNT_W'(on_v[k] && !leave_v[k]);
    for (int k = 0; k < N; k++) begin
      idx = PTR_W'((int'(rr_ptr_q) + k) % N);
      if (!found && wait_v[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
    grant_en = found && (stay_cnt < CNT_W'(MAX_ACTIVE));
    grant_v  = grant_en ? N'(1) << gnt_idx : '0;
    rr_ptr_d = !grant_en ? rr_ptr_q : (gnt_idx == PTR_W'(N - 1)) ? '0 : gnt_idx + PTR_W'(1);
    act_d    = stay_cnt + CNT_W'(grant_en);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      active_cnt <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      active_cnt <= act_d;
    end
  end
`ifdef HEATER_SCHED_ERR_CNT_EN
  logic [15:0] err_sum;
  always_comb begin
    err_sum = {8'd0, err_total};
    for (int k = 0; k < N; k++) err_sum = err_sum + 16'(on_v[k] && heater_error[k]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_total <= '0;
    else err_total <= (err_sum > 16'd255) ? 8'hff : err_sum[7:0];
  end
`endif
endmodule
